// File: rtl/pixel_to_servo_xform.sv
// pixel_to_servo_xform
// Converts a target pixel coordinate into pan/tilt servo pulse-width counts.
// Each axis goes through the same offset -> scale -> divide -> clamp -> deadband
// path, and the two axes share a single bit-serial restoring divider.

module pixel_to_servo_xform #(
    parameter int COORD_W     = 10,
    parameter int OUT_W       = 11,
    parameter int X_RES       = 640,
    parameter int Y_RES       = 480,
    parameter int PAN_CENTER  = 611,
    parameter int TILT_CENTER = 611,
    parameter int PAN_SPAN    = 444,
    parameter int TILT_SPAN   = 333,
    parameter int PAN_INVERT  = 1,
    parameter int TILT_INVERT = 0,
    parameter int OUT_MIN     = 250,
    parameter int OUT_MAX     = 1000,
    parameter int DEADBAND    = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               coord_valid,
    output logic               coord_ready,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [OUT_W-1:0]   pan,
    output logic [OUT_W-1:0]   tilt,
    output logic               out_valid,
    output logic               out_changed
);

    localparam int DIV_STEPS = COORD_W + OUT_W;
    localparam int CNT_W     = $clog2(DIV_STEPS);
    localparam int RW        = COORD_W + 1;
    localparam int TW        = COORD_W + 2;
    localparam int QW        = OUT_W + 1;
    localparam int CW        = OUT_W + 2;

    localparam logic [CNT_W-1:0]     LAST_STEP   = CNT_W'(DIV_STEPS - 1);
    localparam logic [COORD_W-1:0]   X_MAX       = COORD_W'(X_RES - 1);
    localparam logic [COORD_W-1:0]   Y_MAX       = COORD_W'(Y_RES - 1);
    localparam logic [RW-1:0]        X_HALF      = RW'(X_RES / 2);
    localparam logic [RW-1:0]        Y_HALF      = RW'(Y_RES / 2);
    localparam logic [TW-1:0]        X_DIV       = TW'(X_RES);
    localparam logic [TW-1:0]        Y_DIV       = TW'(Y_RES);
    localparam logic [DIV_STEPS-1:0] PAN_SPAN_V  = DIV_STEPS'(PAN_SPAN);
    localparam logic [DIV_STEPS-1:0] TILT_SPAN_V = DIV_STEPS'(TILT_SPAN);
    localparam logic                 PAN_INV_V   = (PAN_INVERT != 0);
    localparam logic                 TILT_INV_V  = (TILT_INVERT != 0);
    localparam logic signed [CW-1:0] PAN_CTR_S   = CW'(PAN_CENTER);
    localparam logic signed [CW-1:0] TILT_CTR_S  = CW'(TILT_CENTER);
    localparam logic signed [CW-1:0] MIN_S       = CW'(OUT_MIN);
    localparam logic signed [CW-1:0] MAX_S       = CW'(OUT_MAX);
    localparam logic signed [CW-1:0] DB_S        = CW'(DEADBAND);
    localparam logic [OUT_W-1:0]     PAN_RST     = OUT_W'(PAN_CENTER);
    localparam logic [OUT_W-1:0]     TILT_RST    = OUT_W'(TILT_CENTER);
    localparam logic [OUT_W-1:0]     MIN_V       = OUT_W'(OUT_MIN);
    localparam logic [OUT_W-1:0]     MAX_V       = OUT_W'(OUT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        LD_PAN,
        DIV_PAN,
        LD_TILT,
        DIV_TILT,
        COMMIT
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   load_en;
    logic                   div_en;
    logic                   commit_en;
    logic                   ld_tilt;
    logic [COORD_W-1:0]     x_q;
    logic [COORD_W-1:0]     y_q;
    logic [COORD_W-1:0]     ld_sat;
    logic [RW-1:0]          ld_off;
    logic [RW-1:0]          ld_mag;
    logic [DIV_STEPS-1:0]   ld_prod;
    logic                   ld_dir;
    logic [DIV_STEPS-1:0]   dividend;
    logic [RW-1:0]          rem;
    logic [QW-1:0]          quot;
    logic [CNT_W-1:0]       step_cnt;
    logic [TW-1:0]          trial;
    logic [TW-1:0]          div_res;
    logic                   trial_ge;
    logic                   pan_dir;
    logic                   tilt_dir;
    logic [OUT_W-1:0]       pan_cand_q;
    logic [OUT_W-1:0]       tilt_cand;
    logic                   pan_upd;
    logic                   tilt_upd;

    // Apply the direction to the quotient around the centre, then clamp to the output range.
    function automatic logic [OUT_W-1:0] make_cand(input logic [QW-1:0] q, input logic dir,
                                                   input logic signed [CW-1:0] center);
        logic signed [CW-1:0] sum;
        sum = dir ? (center - $signed({1'b0, q})) : (center + $signed({1'b0, q}));
        if (sum < MIN_S)
            make_cand = MIN_V;
        else if (sum > MAX_S)
            make_cand = MAX_V;
        else
            make_cand = sum[OUT_W-1:0];
    endfunction

    // True when the candidate has moved further than the deadband from the held value.
    function automatic logic beyond_deadband(input logic [OUT_W-1:0] cand, input logic [OUT_W-1:0] cur);
        logic signed [CW-1:0] diff;
        diff = $signed({2'b00, cand}) - $signed({2'b00, cur});
        if (diff[CW-1])
            diff = -diff;
        beyond_deadband = (diff > DB_S);
    endfunction

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Walk pan then tilt through load and divide, then commit both together.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (coord_valid) state_next = LD_PAN;
            LD_PAN:   state_next = DIV_PAN;
            DIV_PAN:  if (step_cnt == LAST_STEP) state_next = LD_TILT;
            LD_TILT:  state_next = DIV_TILT;
            DIV_TILT: if (step_cnt == LAST_STEP) state_next = COMMIT;
            COMMIT:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        coord_ready = (state == IDLE);
        load_en     = (state == LD_PAN) || (state == LD_TILT);
        div_en      = (state == DIV_PAN) || (state == DIV_TILT);
        commit_en   = (state == COMMIT);
        ld_tilt     = (state == LD_TILT);
    end

    // Saturate the coordinate, centre it and scale its magnitude by the span.
    always_comb begin
        if (ld_tilt)
            ld_sat = (y_q > Y_MAX) ? Y_MAX : y_q;
        else
            ld_sat = (x_q > X_MAX) ? X_MAX : x_q;
        ld_off  = {1'b0, ld_sat} - (ld_tilt ? Y_HALF : X_HALF);
        ld_mag  = ld_off[COORD_W] ? -ld_off : ld_off;
        ld_prod = DIV_STEPS'(ld_mag) * (ld_tilt ? TILT_SPAN_V : PAN_SPAN_V);
        ld_dir  = ld_off[COORD_W] ^ (ld_tilt ? TILT_INV_V : PAN_INV_V);
    end

    // One restoring-division trial per cycle plus the commit-time decisions.
    always_comb begin
        trial     = {rem, dividend[DIV_STEPS-1]};
        div_res   = (state == DIV_TILT) ? Y_DIV : X_DIV;
        trial_ge  = (trial >= div_res);
        tilt_cand = make_cand(quot, tilt_dir, TILT_CTR_S);
        pan_upd   = beyond_deadband(pan_cand_q, pan);
        tilt_upd  = beyond_deadband(tilt_cand, tilt);
    end

    // Coordinate capture, divider state and the parked pan candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            dividend   <= '0;
            rem        <= '0;
            quot       <= '0;
            step_cnt   <= '0;
            pan_dir    <= 1'b0;
            tilt_dir   <= 1'b0;
            pan_cand_q <= '0;
        end else begin
            if (coord_valid && coord_ready) begin
                x_q <= x;
                y_q <= y;
            end
            if (load_en) begin
                dividend <= ld_prod;
                rem      <= '0;
                quot     <= '0;
                step_cnt <= '0;
                if (ld_tilt)
                    tilt_dir <= ld_dir;
                else
                    pan_dir <= ld_dir;
            end
            if (ld_tilt)
                pan_cand_q <= make_cand(quot, pan_dir, PAN_CTR_S);
            if (div_en) begin
                dividend <= {dividend[DIV_STEPS-2:0], 1'b0};
                rem      <= trial_ge ? RW'(trial - div_res) : trial[RW-1:0];
                quot     <= {quot[QW-2:0], trial_ge};
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    // Outputs move only at commit, both axes on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pan         <= PAN_RST;
            tilt        <= TILT_RST;
            out_valid   <= 1'b0;
            out_changed <= 1'b0;
        end else begin
            out_valid   <= commit_en;
            out_changed <= commit_en && (pan_upd || tilt_upd);
            if (commit_en && pan_upd)
                pan <= pan_cand_q;
            if (commit_en && tilt_upd)
                tilt <= tilt_cand;
        end
    end

endmodule

// File: tb/tb_pixel_to_servo_xform.sv
// tb_pixel_to_servo_xform
// Three DUT copies (default, wide pan span, deadband 2) share one stimulus stream
// and are checked every cycle against an arithmetic model of the mapping.

module tb_pixel_to_servo_xform;

    logic        clk;
    logic        rst_n;
    logic        coord_valid;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        ready_o   [3];
    logic [10:0] pan_o     [3];
    logic [10:0] tilt_o    [3];
    logic        ov_o      [3];
    logic        chg_o     [3];

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 0;

    int cfg_span [3] = '{444, 1400, 444};
    int cfg_db   [3] = '{0, 0, 2};

    int m_pan  [3];
    int m_tilt [3];
    bit m_chg  [3];
    bit m_busy;
    bit m_ov;
    int m_cnt;
    int px;
    int py;

    pixel_to_servo_xform u_dut (
        .clk(clk), .rst_n(rst_n), .coord_valid(coord_valid), .coord_ready(ready_o[0]),
        .x(x), .y(y), .pan(pan_o[0]), .tilt(tilt_o[0]), .out_valid(ov_o[0]), .out_changed(chg_o[0])
    );

    pixel_to_servo_xform #(.PAN_SPAN(1400)) u_span (
        .clk(clk), .rst_n(rst_n), .coord_valid(coord_valid), .coord_ready(ready_o[1]),
        .x(x), .y(y), .pan(pan_o[1]), .tilt(tilt_o[1]), .out_valid(ov_o[1]), .out_changed(chg_o[1])
    );

    pixel_to_servo_xform #(.DEADBAND(2)) u_db (
        .clk(clk), .rst_n(rst_n), .coord_valid(coord_valid), .coord_ready(ready_o[2]),
        .x(x), .y(y), .pan(pan_o[2]), .tilt(tilt_o[2]), .out_valid(ov_o[2]), .out_changed(chg_o[2])
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case some wait never completes
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog");
    end

    // Target count for one axis from plain integer arithmetic
    function automatic int axisModel(int c, int res, int center, int span, int inv);
        int s, off, mag, q, cand;
        s    = (c >= res) ? res - 1 : c;
        off  = s - res / 2;
        mag  = (off < 0) ? -off : off;
        q    = (mag * span) / res;
        cand = ((off < 0) != (inv != 0)) ? center - q : center + q;
        if (cand < 250)  cand = 250;
        if (cand > 1000) cand = 1000;
        return cand;
    endfunction

    function automatic bit moves(int cand, int cur, int db);
        int d;
        d = cand - cur;
        if (d < 0) d = -d;
        return d > db;
    endfunction

    function automatic int settle(int cand, int cur, int db);
        return moves(cand, cur, db) ? cand : cur;
    endfunction

    // Reference: accepted coordinate commits 45 cycles after the accept edge
    always @(posedge clk or negedge rst_n) begin
        m_ov <= 1'b0;
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            for (int i = 0; i < 3; i++) begin
                m_pan[i]  <= 611;
                m_tilt[i] <= 611;
                m_chg[i]  <= 1'b0;
            end
        end else if (m_busy) begin
            if (m_cnt == 44) begin
                m_busy <= 1'b0;
                m_ov   <= 1'b1;
                for (int i = 0; i < 3; i++) begin
                    m_pan[i]  <= settle(axisModel(px, 640, 611, cfg_span[i], 1), m_pan[i], cfg_db[i]);
                    m_tilt[i] <= settle(axisModel(py, 480, 611, 333, 0), m_tilt[i], cfg_db[i]);
                    m_chg[i]  <= moves(axisModel(px, 640, 611, cfg_span[i], 1), m_pan[i], cfg_db[i]) ||
                                 moves(axisModel(py, 480, 611, 333, 0), m_tilt[i], cfg_db[i]);
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (coord_valid) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            px     <= int'(x);
            py     <= int'(y);
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle, every instance must match the reference
    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("pan[%0d]", i), int'(pan_o[i]), m_pan[i]);
                checkOutput($sformatf("tilt[%0d]", i), int'(tilt_o[i]), m_tilt[i]);
                checkOutput($sformatf("out_valid[%0d]", i), int'(ov_o[i]), int'(m_ov));
                checkOutput($sformatf("coord_ready[%0d]", i), int'(ready_o[i]), int'(!m_busy));
                if (m_ov)
                    checkOutput($sformatf("out_changed[%0d]", i), int'(chg_o[i]), int'(m_chg[i]));
            end
        end
    end

    task automatic waitReady();
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_o[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o[0]) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL ready_timeout: got coord_ready 0 after 200 cycles, required 1");
        end
    endtask

    task automatic applyStimulus(input logic [9:0] xv, input logic [9:0] yv);
        waitReady();
        #1;
        coord_valid = 1'b1;
        x = xv;
        y = yv;
        @(negedge clk);
        #1 coord_valid = 1'b0;
    endtask

    task automatic waitOutValid(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (ov_o[0]) break;
        end
        if (!ov_o[0]) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL out_valid_timeout: got no out_valid in 100 cycles, required one");
        end
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Directed scenarios followed by a random run
    initial begin
        int lat;
        int pulses;
        coord_valid = 1'b0;
        x = '0;
        y = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checking = 1;
        checkOutput("reset_pan", int'(pan_o[0]), 611);
        checkOutput("reset_tilt", int'(tilt_o[0]), 611);
        checkOutput("reset_ready", int'(ready_o[0]), 1);
        checkOutput("reset_out_valid", int'(ov_o[0]), 0);
        #1 rst_n = 1'b1;

        // Model pins
        checkOutput("model_pan_x0", axisModel(0, 640, 611, 444, 1), 833);
        checkOutput("model_tilt_y0", axisModel(0, 480, 611, 333, 0), 445);
        checkOutput("model_pan_x639", axisModel(639, 640, 611, 444, 1), 390);
        checkOutput("model_tilt_y479", axisModel(479, 480, 611, 333, 0), 776);

        // Centre point
        applyStimulus(10'd320, 10'd240);
        waitOutValid(lat);
        checkOutput("latency", lat, 45);
        checkOutput("centre_pan", int'(pan_o[0]), 611);
        checkOutput("centre_tilt", int'(tilt_o[0]), 611);
        checkOutput("centre_changed", int'(chg_o[0]), 0);

        // Corners, including clamp on the wide-span copy
        applyStimulus(10'd0, 10'd0);
        waitOutValid(lat);
        checkOutput("corner0_pan", int'(pan_o[0]), 833);
        checkOutput("corner0_tilt", int'(tilt_o[0]), 445);
        checkOutput("span_x0_pan", int'(pan_o[1]), 1000);
        applyStimulus(10'd639, 10'd479);
        waitOutValid(lat);
        checkOutput("corner1_pan", int'(pan_o[0]), 390);
        checkOutput("corner1_tilt", int'(tilt_o[0]), 776);
        checkOutput("span_x639_pan", int'(pan_o[1]), 250);

        // Deadband from centre
        pulseReset();
        applyStimulus(10'd322, 10'd240);
        waitOutValid(lat);
        checkOutput("db_322_pan", int'(pan_o[2]), 611);
        checkOutput("db_322_changed", int'(chg_o[2]), 0);
        applyStimulus(10'd324, 10'd240);
        waitOutValid(lat);
        checkOutput("db_324_pan", int'(pan_o[2]), 611);
        checkOutput("db_324_changed", int'(chg_o[2]), 0);
        applyStimulus(10'd326, 10'd240);
        waitOutValid(lat);
        checkOutput("db_326_pan", int'(pan_o[2]), 607);
        checkOutput("db_326_changed", int'(chg_o[2]), 1);

        // coord_valid held high with inputs changing every cycle
        waitReady();
        #1;
        coord_valid = 1'b1;
        x = 10'($urandom_range(0, 1023));
        y = 10'($urandom_range(0, 1023));
        pulses = 0;
        for (int k = 1; k <= 138; k++) begin
            @(negedge clk);
            if (ov_o[0]) pulses++;
            if (k == 1)  checkOutput("busy_ready_first", int'(ready_o[0]), 0);
            if (k == 45) checkOutput("busy_ready_commit", int'(ready_o[0]), 0);
            if (k == 46) checkOutput("ready_after_commit", int'(ready_o[0]), 1);
            #1;
            x = 10'($urandom_range(0, 1023));
            y = 10'($urandom_range(0, 1023));
        end
        coord_valid = 1'b0;
        checkOutput("held_valid_pulses", pulses, 3);

        // Reset in the middle of a transaction
        applyStimulus(10'd0, 10'd0);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_pan", int'(pan_o[0]), 611);
        checkOutput("abort_tilt", int'(tilt_o[0]), 611);
        checkOutput("abort_ready", int'(ready_o[0]), 1);
        #1 rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ov_o[0]) pulses++;
        end
        checkOutput("abort_no_valid", pulses, 0);
        applyStimulus(10'd1023, 10'd1023);
        waitOutValid(lat);
        checkOutput("sat_pan", int'(pan_o[0]), 390);
        checkOutput("sat_tilt", int'(tilt_o[0]), 776);

        // Random coordinates, including saturated ones, with random idle gaps
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
        end
        waitOutValid(lat);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
